// File: rtl/mux_arb_pkg.sv
// Shared types, widths and the round-robin pick helper
// for the 4-source mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int DATA_W  = 4;

    // Returns {found, idx}; the first set bit at or after ptr wins.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4:1 datapath mux, select 0..3 maps to a..d.
// Purely combinational.
module mux_4_to_1
    import mux_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_d,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = i_a;
        case (i_sel)
            2'd0:    o_y = i_a;
            2'd1:    o_y = i_b;
            2'd2:    o_y = i_c;
            default: o_y = i_d;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four
// requesters, with a per-grant beat limit and valid/ready output.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [3:0]         r_beat_cnt;
    logic [NUM_REQ-1:0] r_gnt;

    logic               w_valid;
    logic               w_beat;
    logic               w_release;
    logic [SEL_W-1:0]   w_next_ptr;
    logic [SEL_W-1:0]   w_search;
    logic [SEL_W:0]     w_pick;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_mux;

    assign w_valid    = (r_state == SERVE) & req[r_sel];
    assign w_beat     = w_valid & out_ready;
    assign w_release  = ~req[r_sel]
                      | (w_beat & (r_beat_cnt == LAST_BEAT));
    assign w_next_ptr = r_sel + 2'd1;

    // On release the search starts just past the current owner.
    assign w_search = (r_state == IDLE) ? r_ptr : w_next_ptr;
    assign w_pick   = rr_pick(req, w_search);
    assign w_found  = w_pick[SEL_W];
    assign w_idx    = w_pick[SEL_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_gnt      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel      <= w_idx;
                        r_gnt      <= NUM_REQ'(1) << w_idx;
                        r_beat_cnt <= '0;
                        r_state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (w_release) begin
                        r_ptr      <= w_next_ptr;
                        r_beat_cnt <= '0;
                        if (w_found) begin
                            r_sel <= w_idx;
                            r_gnt <= NUM_REQ'(1) << w_idx;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    mux_4_to_1 u_mux (
        .i_a   (a),
        .i_b   (b),
        .i_c   (c),
        .i_d   (d),
        .i_sel (r_sel),
        .o_y   (w_mux)
    );

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = (r_state == SERVE);
    assign out_valid = w_valid;
    assign out       = w_valid ? w_mux : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: BURST=4 and BURST=1
// instances share stimulus; expected values are hand-computed.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic       out_ready;

    logic [3:0] gnt, out;
    logic [1:0] sel;
    logic       out_valid, busy;

    logic [3:0] gnt1, out1;
    logic [1:0] sel1;
    logic       ov1, busy1;

    int n_err = 0;
    int n_chk = 0;
    int beats [4];
    int snap;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .sel(sel), .out_valid(out_valid),
        .out(out), .out_ready(out_ready), .busy(busy)
    );

    rr_mux_arbiter #(.BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt1), .sel(sel1), .out_valid(ov1),
        .out(out1), .out_ready(out_ready), .busy(busy1)
    );

    initial begin
        for (int i = 0; i < 4; i++) beats[i] = 0;
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            beats[sel] <= beats[sel] + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        out_ready = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // single requester b
        nxt();
        req = 4'b0010; b = 4'hA; out_ready = 1'b1;
        @(negedge clk);
        check("single_lat_gnt", 32'(gnt), 32'h0);
        nxt();
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'h2);
        check("single_sel", 32'(sel), 32'h1);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_out", 32'(out), 32'hA);
        check("single_busy", 32'(busy), 32'h1);
        nxt();
        @(negedge clk);
        check("single_out2", 32'(out), 32'hA);
        nxt();
        req = 4'b0000;
        @(negedge clk);
        check("single_drop_valid", 32'(out_valid), 32'h0);
        nxt();
        @(negedge clk);
        check("single_idle_busy", 32'(busy), 32'h0);
        check("single_idle_gnt", 32'(gnt), 32'h0);
        check("single_ptr", 32'(dut.r_ptr), 32'h2);

        // round robin, BURST=1 instance
        b = 4'h2;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            nxt();
            @(negedge clk);
            check("rr_sel", 32'(sel1), 32'(k % 4));
            check("rr_out", 32'(out1), 32'(k % 4 + 1));
        end

        // burst limit, BURST=4 instance
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 12; k++) begin
            nxt();
            @(negedge clk);
            check("burst_sel", 32'(sel), ((k / 4) % 2) ? 32'h2 : 32'h0);
            check("burst_out", 32'(out), ((k / 4) % 2) ? 32'h3 : 32'h1);
            check("burst_cnt", 32'(dut.r_beat_cnt), 32'(k % 4));
        end

        // backpressure on d
        do_reset();
        out_ready = 1'b0;
        req = 4'b1000; d = 4'h7;
        for (int k = 0; k < 5; k++) begin
            nxt();
            @(negedge clk);
            check("bp_gnt", 32'(gnt), 32'h8);
            check("bp_out", 32'(out), 32'h7);
            check("bp_cnt", 32'(dut.r_beat_cnt), 32'h0);
        end
        nxt();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'h1);
        check("bp_cnt_hold", 32'(dut.r_beat_cnt), 32'h0);
        nxt();
        @(negedge clk);
        check("bp_cnt_after", 32'(dut.r_beat_cnt), 32'h1);
        check("bp_gnt_after", 32'(gnt), 32'h8);

        // a drops after two beats
        do_reset();
        a = 4'h1; b = 4'h2; d = 4'h4;
        req = 4'b0011;
        snap = beats[0];
        nxt();
        nxt();
        nxt();
        req = 4'b0010;
        @(negedge clk);
        check("drop_valid", 32'(out_valid), 32'h0);
        check("drop_out", 32'(out), 32'h0);
        nxt();
        @(negedge clk);
        check("drop_gnt", 32'(gnt), 32'h2);
        check("drop_sel", 32'(sel), 32'h1);
        check("drop_beats_a", 32'(beats[0] - snap), 32'h2);

        // reset while b has a beat pending
        nxt();
        check("pre_rst_cnt", 32'(dut.r_beat_cnt), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        nxt();
        rst = 1'b0;
        req = 4'b1000;
        @(negedge clk);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_cnt", 32'(dut.r_beat_cnt), 32'h0);
        nxt();
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt), 32'h8);
        check("post_rst_sel", 32'(sel), 32'h3);
        check("post_rst_out", 32'(out), 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
